// File: rtl/alu_flag_stage_if.sv
// ---------------------------------------------------------------------------
// alu_flag_stage_if
// Bundles the signals of the ALU result/flag stage into one interface.
//
// Upstream beat (adder side):
//   in_valid, in_ready, a, b, s (adder sum), ovf (adder carry-out)
// Downstream beat (consumer side):
//   out_valid, out_ready, res, flag_z, flag_n, flag_c, flag_v
// Status:
//   sticky_c, sticky_v (sticky carry/overflow), clr (software clear)
//
// Modports:
//   master - the environment: drives beats, out_ready and clr
//   slave  - the stage itself
// ---------------------------------------------------------------------------
interface alu_flag_stage_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] s;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] res;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;
  logic         sticky_c;
  logic         sticky_v;
  logic         clr;

  modport master (
    output in_valid, a, b, s, ovf, out_ready, clr,
    input  in_ready, out_valid, res, flag_z, flag_n, flag_c, flag_v,
           sticky_c, sticky_v
  );

  modport slave (
    input  in_valid, a, b, s, ovf, out_ready, clr,
    output in_ready, out_valid, res, flag_z, flag_n, flag_c, flag_v,
           sticky_c, sticky_v
  );
endinterface

// File: rtl/alu_flag_stage.sv
// ---------------------------------------------------------------------------
// alu_flag_stage
// Registered result/flag stage behind the N-bit ripple-carry adder.
// Captures sum, carry-out and operands at accept, derives Z/N/C/V flags,
// and presents them on a valid/ready output through a 2-entry skid buffer
// (output register + one skid register) so the adder runs at full rate
// under backpressure. Keeps sticky carry/overflow bits, cleared by clr.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - alu_flag_stage_if.slave (beats in, result/flags out, sticky)
// ---------------------------------------------------------------------------
module alu_flag_stage #(
  parameter int N = 4
) (
  input logic                 clk,
  input logic                 rst,
  alu_flag_stage_if.slave     bus
);

  // Stored beat layout: {c, v, n, z, res[N-1:0]}
  localparam int W = N + 4;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  // Builds a stored beat from the sampled adder inputs.
  function automatic logic [W-1:0] make_beat(
    input logic [N-1:0] op_a,
    input logic [N-1:0] op_b,
    input logic [N-1:0] sum,
    input logic         carry
  );
    logic z;
    logic n;
    logic v;
    z = (sum == {N{1'b0}});
    n = sum[N-1];
    // Signed overflow: operands share a sign and the sum's sign differs.
    v = (op_a[N-1] == op_b[N-1]) & (sum[N-1] != op_a[N-1]);
    return {carry, v, n, z, sum};
  endfunction

  logic [1:0]   state;
  logic [1:0]   state_next;
  logic [W-1:0] out_beat;
  logic [W-1:0] skid_beat;
  logic [W-1:0] in_beat;
  logic         valid_reg;
  logic         ready_reg;
  logic         sticky_c_reg;
  logic         sticky_v_reg;
  logic         sticky_c_next;
  logic         sticky_v_next;
  logic         accept;
  logic         deliver;
  logic         load_out_in;
  logic         load_out_skid;
  logic         load_skid;

  assign in_beat = make_beat(bus.a, bus.b, bus.s, bus.ovf);
  assign accept  = bus.in_valid & ready_reg;
  assign deliver = valid_reg & bus.out_ready;

  // Next-state and register-load selection for the two-entry buffer.
  always_comb begin
    state_next    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next  = ONE;
          load_out_in = 1'b1;
        end else begin
          state_next = EMPTY;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          state_next  = ONE;
          load_out_in = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (deliver) begin
          state_next = EMPTY;
        end else begin
          state_next = ONE;
        end
      end
      TWO: begin
        // in_ready is low here, so only a deliver can move the state.
        if (deliver) begin
          state_next    = ONE;
          load_out_skid = 1'b1;
        end else begin
          state_next = TWO;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Sticky status: a set from the delivered beat beats a same-cycle clr.
  always_comb begin
    sticky_c_next = (bus.clr ? 1'b0 : sticky_c_reg) | (deliver & out_beat[W-1]);
    sticky_v_next = (bus.clr ? 1'b0 : sticky_v_reg) | (deliver & out_beat[W-2]);
  end

  // State, beat storage, handshake outputs and sticky bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      out_beat     <= {W{1'b0}};
      skid_beat    <= {W{1'b0}};
      valid_reg    <= 1'b0;
      ready_reg    <= 1'b0;
      sticky_c_reg <= 1'b0;
      sticky_v_reg <= 1'b0;
    end else begin
      state        <= state_next;
      valid_reg    <= (state_next != EMPTY);
      ready_reg    <= (state_next != TWO);
      sticky_c_reg <= sticky_c_next;
      sticky_v_reg <= sticky_v_next;
      if (load_out_in) begin
        out_beat <= in_beat;
      end else if (load_out_skid) begin
        out_beat <= skid_beat;
      end else begin
        out_beat <= out_beat;
      end
      if (load_skid) begin
        skid_beat <= in_beat;
      end else begin
        skid_beat <= skid_beat;
      end
    end
  end

  assign bus.in_ready  = ready_reg;
  assign bus.out_valid = valid_reg;
  assign bus.res       = out_beat[N-1:0];
  assign bus.flag_z    = out_beat[W-4];
  assign bus.flag_n    = out_beat[W-3];
  assign bus.flag_v    = out_beat[W-2];
  assign bus.flag_c    = out_beat[W-1];
  assign bus.sticky_c  = sticky_c_reg;
  assign bus.sticky_v  = sticky_v_reg;

endmodule

// File: tb/tb_alu_flag_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_flag_stage
// Self-checking bench for alu_flag_stage (N=4): directed steps followed by
// randomized traffic, all checked against an arithmetic reference model
// holding a FIFO of expected beats.
// ---------------------------------------------------------------------------
module tb_alu_flag_stage;
  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } beat_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  beat_t q[$];
  bit    m_rdy;
  bit    m_sc;
  bit    m_sv;
  bit    m_zero;

  alu_flag_stage_if #(.N(N)) bus ();

  alu_flag_stage #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain integer arithmetic on the operands.
  function automatic beat_t ref_beat(input int ua, input int ub);
    beat_t r;
    int sum;
    int sa;
    int sb;
    int m;
    sum   = ua + ub;
    m     = sum % (1 << N);
    sa    = (ua >= (1 << (N - 1))) ? ua - (1 << N) : ua;
    sb    = (ub >= (1 << (N - 1))) ? ub - (1 << N) : ub;
    r.res = N'(m);
    r.z   = (m == 0);
    r.n   = (m >= (1 << (N - 1)));
    r.c   = (sum >= (1 << N));
    r.v   = ((sa + sb) > ((1 << (N - 1)) - 1)) || ((sa + sb) < -(1 << (N - 1)));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic ordy, input logic cl);
    logic [N:0] sum;
    sum           = {1'b0, av} + {1'b0, bv};
    bus.in_valid  = iv;
    bus.a         = av;
    bus.b         = bv;
    bus.s         = sum[N-1:0];
    bus.ovf       = sum[N];
    bus.out_ready = ordy;
    bus.clr       = cl;
  endtask

  // Advance the model across one edge, then compare all outputs after it.
  task automatic cyc();
    bit    acc;
    bit    del;
    beat_t f;
    beat_t e;
    if (rst) begin
      q.delete();
      m_rdy  = 1'b0;
      m_sc   = 1'b0;
      m_sv   = 1'b0;
      m_zero = 1'b1;
    end else begin
      acc = bus.in_valid && m_rdy;
      del = (q.size() > 0) && bus.out_ready;
      if (del) begin
        f    = q.pop_front();
        m_sc = bus.clr ? f.c : (m_sc | f.c);
        m_sv = bus.clr ? f.v : (m_sv | f.v);
      end else if (bus.clr) begin
        m_sc = 1'b0;
        m_sv = 1'b0;
      end
      if (acc) begin
        q.push_back(ref_beat(int'(bus.a), int'(bus.b)));
        m_zero = 1'b0;
      end
      m_rdy = (q.size() < 2);
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("sticky_c", 32'(bus.sticky_c), 32'(m_sc));
    chk("sticky_v", 32'(bus.sticky_v), 32'(m_sv));
    if (q.size() > 0 || m_zero) begin
      e = (q.size() > 0) ? q[0] : '0;
      chk("res", 32'(bus.res), 32'(e.res));
      chk("flag_z", 32'(bus.flag_z), 32'(e.z));
      chk("flag_n", 32'(bus.flag_n), 32'(e.n));
      chk("flag_c", 32'(bus.flag_c), 32'(e.c));
      chk("flag_v", 32'(bus.flag_v), 32'(e.v));
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    m_rdy  = 1'b0;
    m_sc   = 1'b0;
    m_sv   = 1'b0;
    m_zero = 1'b1;
    rst    = 1'b1;
    drive(1'b1, 4'd3, 4'd4, 1'b1, 1'b0);

    // Reset held two cycles with in_valid high.
    cyc();
    cyc();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_nobeat", 32'(bus.out_valid), 32'd0);

    // 0111 + 0001 -> 1000, signed overflow, one-cycle valid.
    drive(1'b1, 4'b0111, 4'b0001, 1'b1, 1'b0);
    cyc();
    chk("p1_res", 32'(bus.res), 32'h8);
    chk("p1_n", 32'(bus.flag_n), 32'd1);
    chk("p1_v", 32'(bus.flag_v), 32'd1);
    chk("p1_c", 32'(bus.flag_c), 32'd0);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    cyc();
    chk("p1_one_cycle", 32'(bus.out_valid), 32'd0);

    // 1111 + 0001 -> 0000 with carry.
    drive(1'b1, 4'b1111, 4'b0001, 1'b1, 1'b0);
    cyc();
    chk("p2_z", 32'(bus.flag_z), 32'd1);
    chk("p2_c", 32'(bus.flag_c), 32'd1);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    cyc();
    chk("p2_sticky_c", 32'(bus.sticky_c), 32'd1);

    // Backpressure: beats 1,2,3 with out_ready low, then drain.
    drive(1'b1, 4'd1, 4'd0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 4'd2, 4'd0, 1'b0, 1'b0);
    cyc();
    chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 4'd3, 4'd0, 1'b0, 1'b0);
    cyc();
    chk("bp_hold_res", 32'(bus.res), 32'd1);
    drive(1'b1, 4'd3, 4'd0, 1'b1, 1'b0);
    cyc();
    chk("bp_res2", 32'(bus.res), 32'd2);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    cyc();
    chk("bp_res3", 32'(bus.res), 32'd3);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    cyc();

    // Full throughput: 8 beats back-to-back.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'(i), 4'd0, 1'b1, 1'b0);
      cyc();
      chk("tp_res", 32'(bus.res), 32'(i));
    end
    drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    cyc();

    // Sticky: set by delivery, set wins over clr, clr alone clears.
    chk("st_cleared", 32'(bus.sticky_v), 32'd0);
    drive(1'b1, 4'b0111, 4'b0001, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    cyc();
    chk("st_set_v", 32'(bus.sticky_v), 32'd1);
    drive(1'b1, 4'b0111, 4'b0001, 1'b1, 1'b0);
    cyc();
    drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    cyc();
    chk("st_set_wins", 32'(bus.sticky_v), 32'd1);
    drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    cyc();
    chk("st_clr_v", 32'(bus.sticky_v), 32'd0);
    chk("st_clr_c", 32'(bus.sticky_c), 32'd0);

    // Randomized traffic with occasional reset and clear.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
            1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 7) == 0));
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
